// File: rtl/mlow_pkg.sv
// mlow_pkg: scheduler state/error encodings, config limits, core reset defaults and the config validity check
package mlow_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CONFIG, ST_STREAM, ST_DRAIN, ST_DONE, ST_ERROR
    } sched_state_e;
    typedef enum logic [1:0] {
        ERR_CFG = 2'd0, ERR_TIMEOUT = 2'd1, ERR_CORE = 2'd2, ERR_ABORT = 2'd3
    } sched_err_e;
    localparam logic [3:0] MLOW_MAX_BITRATE_SEL = 4'd7;
    localparam logic [1:0] MLOW_BW_INVALID      = 2'b11;
    localparam logic [3:0] MLOW_RST_BITRATE     = 4'h3;
    localparam logic [1:0] MLOW_RST_BANDWIDTH   = 2'b01;
    function automatic logic cfg_bad(input logic [3:0] br, input logic [1:0] bw);
        return br > MLOW_MAX_BITRATE_SEL || bw == MLOW_BW_INVALID;
    endfunction
endpackage

// File: rtl/mlow_rr_arb2.sv
// mlow_rr_arb2: 2-way round-robin winner (win_enc) from enc_req/dec_req and a last-served flag updated on upd with upd_enc
module mlow_rr_arb2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enc_req,
    input  logic dec_req,
    input  logic upd,
    input  logic upd_enc,
    output logic win_enc
);
    logic last_enc;
    always_ff @(posedge clk_i) begin
        if (reset_i) last_enc <= 1'b0;
        else if (upd) last_enc <= upd_enc;
    end
    assign win_enc = enc_req && (!dec_req || !last_enc);
endmodule

// File: rtl/mlow_frame_scheduler.sv
// mlow_frame_scheduler: shares one mlow_codec core between enc/dec requesters (req/cfg in, grant out), drives core_* cfg, counts beats, reports job_done/job_error+err_code and frame_count
module mlow_frame_scheduler
    import mlow_pkg::*;
#(
    parameter int FRAME_SIZE     = 480,
    parameter int PKT_BYTES      = 240,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MIN_DRAIN      = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enc_req_i,
    input  logic [3:0]  enc_bitrate_i,
    input  logic [1:0]  enc_bandwidth_i,
    output logic        enc_grant_o,
    input  logic        dec_req_i,
    input  logic [3:0]  dec_bitrate_i,
    input  logic [1:0]  dec_bandwidth_i,
    output logic        dec_grant_o,
    output logic        core_encode_mode_o,
    output logic [3:0]  core_bitrate_sel_o,
    output logic [1:0]  core_bandwidth_sel_o,
    input  logic        core_beat_i,
    input  logic        core_busy_i,
    input  logic        core_error_i,
    output logic        job_done_o,
    output logic        job_error_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] frame_count_o
);
    localparam int BW = $clog2((FRAME_SIZE > PKT_BYTES ? FRAME_SIZE : PKT_BYTES) + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(MIN_DRAIN + 1);
    sched_state_e  state;
    logic [BW-1:0] beat_cnt;
    logic [WW-1:0] wdog;
    logic [DW-1:0] drain_cnt;
    logic          win_enc, req, beat, last_beat, tmo, drained;
    mlow_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enc_req (enc_req_i),
        .dec_req (dec_req_i),
        .upd     (state == ST_DONE || state == ST_ERROR),
        .upd_enc (core_encode_mode_o),
        .win_enc (win_enc)
    );
    assign req         = core_encode_mode_o ? enc_req_i : dec_req_i;
    assign beat        = state == ST_STREAM && core_beat_i;
    assign last_beat   = beat && beat_cnt == BW'(core_encode_mode_o ? FRAME_SIZE - 1 : PKT_BYTES - 1);
    // A beat resets the watchdog, so it can only expire on a beat-free cycle
    assign tmo         = !beat && wdog == WW'(TIMEOUT_CYCLES - 1);
    assign drained     = drain_cnt >= DW'(MIN_DRAIN - 1) && !core_busy_i;
    assign enc_grant_o = state != ST_IDLE && core_encode_mode_o;
    assign dec_grant_o = state != ST_IDLE && !core_encode_mode_o;
    assign job_done_o  = state == ST_DONE;
    assign job_error_o = state == ST_ERROR;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state                <= ST_IDLE;
            core_encode_mode_o   <= 1'b0;
            core_bitrate_sel_o   <= MLOW_RST_BITRATE;
            core_bandwidth_sel_o <= MLOW_RST_BANDWIDTH;
            beat_cnt             <= '0;
            wdog                 <= '0;
            drain_cnt            <= '0;
            err_code_o           <= '0;
            frame_count_o        <= '0;
        end else begin
            case (state)
                ST_IDLE: if (enc_req_i || dec_req_i) begin
                    state                <= ST_CONFIG;
                    core_encode_mode_o   <= win_enc;
                    core_bitrate_sel_o   <= win_enc ? enc_bitrate_i : dec_bitrate_i;
                    core_bandwidth_sel_o <= win_enc ? enc_bandwidth_i : dec_bandwidth_i;
                    beat_cnt             <= '0;
                    wdog                 <= '0;
                end
                ST_CONFIG: if (cfg_bad(core_bitrate_sel_o, core_bandwidth_sel_o)) begin
                    state      <= ST_ERROR;
                    err_code_o <= ERR_CFG;
                end else state <= ST_STREAM;
                ST_STREAM, ST_DRAIN: begin
                    if (core_error_i || !req || tmo) begin
                        state      <= ST_ERROR;
                        err_code_o <= core_error_i ? ERR_CORE : !req ? ERR_ABORT : ERR_TIMEOUT;
                    end else if (last_beat) begin
                        state     <= ST_DRAIN;
                        wdog      <= '0;
                        drain_cnt <= '0;
                    end else if (state == ST_DRAIN && drained) begin
                        state <= ST_DONE;
                    end else begin
                        wdog     <= beat ? '0 : wdog + 1'b1;
                        beat_cnt <= beat_cnt + BW'(beat);
                        if (state == ST_DRAIN && drain_cnt != DW'(MIN_DRAIN)) drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    frame_count_o <= frame_count_o + 16'd1;
                end
                ST_ERROR: begin
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                    wdog     <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlow_frame_scheduler.sv
// tb_mlow_frame_scheduler: randomized jobs against a job-level reference model with a pulse-driven scoreboard
module tb_mlow_frame_scheduler;
    localparam int FS = 480;
    localparam int PB = 240;
    localparam int TO = 4096;
    logic        clk_i = 1'b0, reset_i = 1'b1;
    logic        enc_req_i = 1'b0, dec_req_i = 1'b0;
    logic [3:0]  enc_bitrate_i = '0, dec_bitrate_i = '0;
    logic [1:0]  enc_bandwidth_i = '0, dec_bandwidth_i = '0;
    logic        core_beat_i = 1'b0, core_busy_i = 1'b0, core_error_i = 1'b0;
    logic        enc_grant_o, dec_grant_o, core_encode_mode_o, job_done_o, job_error_o;
    logic [3:0]  core_bitrate_sel_o;
    logic [1:0]  core_bandwidth_sel_o, err_code_o;
    logic [15:0] frame_count_o;
    typedef struct {
        bit          done;
        logic [1:0]  code;
        bit          enc;
        logic [15:0] fc;
    } exp_t;
    exp_t        sb[$];
    int          tests = 0, fails = 0;
    bit          last_enc = 1'b0;
    logic [15:0] fc_model = '0;
    always #5 clk_i = ~clk_i;
    mlow_frame_scheduler #(.FRAME_SIZE(FS), .PKT_BYTES(PB), .TIMEOUT_CYCLES(TO), .MIN_DRAIN(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .enc_req_i(enc_req_i), .enc_bitrate_i(enc_bitrate_i), .enc_bandwidth_i(enc_bandwidth_i), .enc_grant_o(enc_grant_o),
        .dec_req_i(dec_req_i), .dec_bitrate_i(dec_bitrate_i), .dec_bandwidth_i(dec_bandwidth_i), .dec_grant_o(dec_grant_o),
        .core_encode_mode_o(core_encode_mode_o), .core_bitrate_sel_o(core_bitrate_sel_o),
        .core_bandwidth_sel_o(core_bandwidth_sel_o), .core_beat_i(core_beat_i), .core_busy_i(core_busy_i),
        .core_error_i(core_error_i), .job_done_o(job_done_o), .job_error_o(job_error_o),
        .err_code_o(err_code_o), .frame_count_o(frame_count_o)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic chk_reset();
        chk("rst_grants", {enc_grant_o, dec_grant_o}, 0);
        chk("rst_pulses", {job_done_o, job_error_o}, 0);
        chk("rst_err_code", err_code_o, 0);
        chk("rst_frame_count", frame_count_o, 0);
        chk("rst_core_cfg", {core_encode_mode_o, core_bitrate_sel_o, core_bandwidth_sel_o}, {1'b0, 4'h3, 2'b01});
    endtask
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(job_done_o || job_error_o) && n < 20000);
        if (!(job_done_o || job_error_o)) begin
            tests++;
            fails++;
            $display("FAIL pulse_wait: no done/error within %0d cycles", n);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    endtask
    // scen: 0 clean frame, 1 stall after k beats, 2 core error in DRAIN with req drop,
    // 3 requester drops after k beats, 4 reset after k beats. Called at a negedge while the DUT is idle.
    task automatic job(input bit er, input bit dr, input logic [3:0] ebr, input logic [1:0] ebw,
                       input logic [3:0] dbr, input logic [1:0] dbw, input int scen, input int k);
        bit w, bad;
        logic [3:0] br;
        logic [1:0] bw;
        int tgt, nb, n;
        exp_t e;
        enc_req_i = er; dec_req_i = dr;
        enc_bitrate_i = ebr; enc_bandwidth_i = ebw; dec_bitrate_i = dbr; dec_bandwidth_i = dbw;
        core_busy_i = 1'b1; core_beat_i = 1'b0; core_error_i = 1'b0;
        w   = er && (!dr || !last_enc);
        br  = w ? ebr : dbr;
        bw  = w ? ebw : dbw;
        bad = br > 4'd7 || bw == 2'd3;
        tgt = w ? FS : PB;
        if (bad || scen != 4) begin
            e.done = !bad && scen == 0;
            e.code = bad ? 2'd0 : 2'(scen);
            e.enc  = w;
            e.fc   = e.done ? fc_model + 16'd1 : fc_model;
            sb.push_back(e);
            fc_model = e.fc;
            last_enc = w;
        end
        @(negedge clk_i);
        chk("grant", {enc_grant_o, dec_grant_o}, w ? 2'b10 : 2'b01);
        chk("core_cfg", {core_encode_mode_o, core_bitrate_sel_o, core_bandwidth_sel_o}, {w, br, bw});
        if (!bad) begin
            nb = (scen == 0 || scen == 2) ? tgt : k;
            n = 0;
            while (n < nb) begin
                @(negedge clk_i);
                core_beat_i = ($urandom_range(0, 2) != 0);
                if (core_beat_i) n++;
            end
            @(negedge clk_i);
            core_beat_i = 1'b0;
            if (scen == 0) begin
                repeat ($urandom_range(0, 5)) @(negedge clk_i);
                core_busy_i = 1'b0;
            end else if (scen == 2 || scen == 3) begin
                core_error_i = (scen == 2);
                if (w) enc_req_i = 1'b0;
                else dec_req_i = 1'b0;
            end else if (scen == 4) begin
                reset_i = 1'b1;
                @(negedge clk_i);
                reset_i = 1'b0;
                enc_req_i = 1'b0; dec_req_i = 1'b0; core_busy_i = 1'b0;
                chk_reset();
                sb.delete();
                last_enc = 1'b0;
                fc_model = '0;
                return;
            end
        end
        wait_pulse(n);
        if (!bad && scen == 1) chk("timeout_latency", n, TO);
        core_error_i = 1'b0; core_beat_i = 1'b0; core_busy_i = 1'b0;
        @(negedge clk_i);
        chk("idle_outputs", {enc_grant_o, dec_grant_o, job_done_o, job_error_o}, 0);
    endtask
    initial begin
        bit pend;
        logic [15:0] pfc;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk_i);
            if (pend) begin
                chk("frame_count", frame_count_o, pfc);
                pend = 1'b0;
            end
            if (job_done_o || job_error_o) begin
                if (sb.size() == 0) chk("unexpected_pulse", {job_done_o, job_error_o}, 0);
                else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {job_done_o, job_error_o}, e.done ? 2'b10 : 2'b01);
                    if (!e.done) chk("err_code", err_code_o, e.code);
                    chk("grant_at_end", {enc_grant_o, dec_grant_o}, e.enc ? 2'b10 : 2'b01);
                    pend = 1'b1;
                    pfc  = e.fc;
                end
            end
        end
    end
    initial begin
        int sc;
        bit er, dr;
        repeat (3) @(negedge clk_i);
        chk_reset();
        reset_i = 1'b0;
        job(1, 0, 4'd3, 2'd1, 4'd0, 2'd0, 0, 0);
        repeat (4) job(1, 1, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                       4'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 0, 0);
        job(0, 1, 4'd0, 2'd0, 4'd2, 2'd3, 0, 0);
        job(1, 0, 4'd5, 2'd2, 4'd0, 2'd0, 1, 100);
        job(1, 0, 4'd4, 2'd0, 4'd0, 2'd0, 2, 0);
        job(0, 1, 4'd0, 2'd0, 4'd6, 2'd2, 3, 50);
        for (int i = 0; i < 8; i++) begin
            er = 1'($urandom_range(0, 1));
            dr = er ? 1'($urandom_range(0, 1)) : 1'b1;
            sc = $urandom_range(0, 3);
            sc = sc == 1 ? 0 : sc;
            job(er, dr, 4'($urandom_range(0, 9)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 9)), 2'($urandom_range(0, 3)), sc, $urandom_range(1, 200));
        end
        job(1, 0, 4'd7, 2'd2, 4'd0, 2'd0, 0, 0);
        job(1, 0, 4'd5, 2'd2, 4'd0, 2'd0, 4, 30);
        job(1, 1, 4'd2, 2'd0, 4'd1, 2'd1, 0, 0);
        repeat (2) @(negedge clk_i);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
